// File: rtl/intg_window_averager_if.sv
// Result handshake bundle for the window averager.
// Producer holds data stable while out_valid is high.
interface intg_window_averager_if #(
    parameter int SUM_W = 13,
    parameter int CNT_W = 5,
    parameter int AVG_W = 9
);
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] sum_out;
    logic [CNT_W-1:0] cnt_out;
    logic [AVG_W-1:0] avg_out;
    logic             avg_sat;

    modport master (
        output out_valid,
        output sum_out,
        output cnt_out,
        output avg_out,
        output avg_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  sum_out,
        input  cnt_out,
        input  avg_out,
        input  avg_sat,
        output out_ready
    );
endinterface

// File: rtl/intg_window_averager.sv
// Integration window averager: captures the window sum and sample count,
// divides serially and holds the result until the consumer takes it.
module intg_window_averager #(
    parameter int SUM_W = 13,
    parameter int CNT_W = 5,
    parameter int AVG_W = 9
) (
    input  logic                  clk,
    input  logic                  acc_rst2,
    input  logic [SUM_W-1:0]      acc_sum,
    input  logic                  acc_en,
    output logic                  overrun,
    intg_window_averager_if.master out_if
);
    localparam int STEP_W = $clog2(SUM_W + 1);
    localparam logic [SUM_W-1:0] AVG_MAX = SUM_W'((64'd1 << AVG_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, DIVIDE, HOLD} state_t;

    state_t            state;
    logic              en_q;
    logic [CNT_W-1:0]  win_cnt;
    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  quo;
    logic [CNT_W-1:0]  rem;
    logic [STEP_W-1:0] step;
    logic              valid_q;
    logic [SUM_W-1:0]  sum_o;
    logic [CNT_W-1:0]  cnt_o;
    logic [AVG_W-1:0]  avg_o;
    logic              sat_o;
    logic              ovr_q;

    logic              capture;
    logic              accept;
    logic [CNT_W:0]    shifted;
    logic [CNT_W:0]    diff;
    logic              ge;
    logic [CNT_W-1:0]  rem_n;
    logic [AVG_W-1:0]  avg_n;
    logic              sat_n;

    assign capture = en_q & ~acc_en;
    assign accept  = valid_q & out_if.out_ready;

    // Restoring step: remainder stays below the divisor, so CNT_W bits suffice.
    always_comb begin
        shifted = {rem, quo[SUM_W-1]};
        diff    = shifted - {1'b0, cnt_q};
        ge      = (shifted >= {1'b0, cnt_q});
        rem_n   = ge ? diff[CNT_W-1:0] : shifted[CNT_W-1:0];
    end

    always_comb begin
        avg_n = '0;
        sat_n = 1'b0;
        if (cnt_q == '0) begin
            avg_n = '0;
        end else if (quo > AVG_MAX) begin
            avg_n = '1;
            sat_n = 1'b1;
        end else begin
            avg_n = quo[AVG_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge acc_rst2) begin
        if (acc_rst2) begin
            en_q    <= 1'b0;
            win_cnt <= '0;
        end else begin
            en_q <= acc_en;
            if (capture)
                win_cnt <= '0;
            else if (acc_en && win_cnt != '1)
                win_cnt <= win_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge acc_rst2) begin
        if (acc_rst2) begin
            state   <= IDLE;
            sum_q   <= '0;
            cnt_q   <= '0;
            quo     <= '0;
            rem     <= '0;
            step    <= '0;
            valid_q <= 1'b0;
            sum_o   <= '0;
            cnt_o   <= '0;
            avg_o   <= '0;
            sat_o   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        state <= DIVIDE;
                        sum_q <= acc_sum;
                        cnt_q <= win_cnt;
                        quo   <= acc_sum;
                        rem   <= '0;
                        step  <= '0;
                    end
                end
                DIVIDE: begin
                    if (capture)
                        ovr_q <= 1'b1;
                    if (step != STEP_W'(SUM_W)) begin
                        quo  <= {quo[SUM_W-2:0], ge};
                        rem  <= rem_n;
                        step <= step + 1'b1;
                    end else begin
                        state   <= HOLD;
                        valid_q <= 1'b1;
                        sum_o   <= sum_q;
                        cnt_o   <= cnt_q;
                        avg_o   <= avg_n;
                        sat_o   <= sat_n;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (capture) begin
                            state <= DIVIDE;
                            sum_q <= acc_sum;
                            cnt_q <= win_cnt;
                            quo   <= acc_sum;
                            rem   <= '0;
                            step  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (capture) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.sum_out   = sum_o;
    assign out_if.cnt_out   = cnt_o;
    assign out_if.avg_out   = avg_o;
    assign out_if.avg_sat   = sat_o;
    assign overrun          = ovr_q;
endmodule

// File: doc/intg_window_averager.md
INTG_WINDOW_AVERAGER -- requirements
Module: intg_window_averager

Interface
REQ-001 Parameter SUM_W, default 13, width of the accumulated sum input.
REQ-002 Parameter CNT_W, default 5, width of the window sample counter.
REQ-003 Parameter AVG_W, default 9, width of the average output.
REQ-004 clk  input  1  rising-edge clock for all sequential logic.
REQ-005 acc_rst2  input  1  reset, asynchronous, active-high.
REQ-006 acc_sum  input  SUM_W  running integrator sum from the upstream accumulator stage.
REQ-007 acc_en  input  1  integration window enable; high = window open.
REQ-008 out_ready  input  1  downstream consumer ready.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 sum_out  output  SUM_W  captured window sum.
REQ-011 cnt_out  output  CNT_W  captured window sample count.
REQ-012 avg_out  output  AVG_W  sum_out / cnt_out, truncated and saturated.
REQ-013 avg_sat  output  1  avg_out was saturated for the held result.
REQ-014 overrun  output  1  sticky flag: a completed window was discarded.

Function
REQ-015 The block SHALL register acc_en into en_q every edge; a window closes on the edge where acc_en=0 and en_q=1 (the capture edge C).
REQ-016 The sample counter SHALL increment on each edge with acc_en=1 and saturate at 2^CNT_W-1 (31).
REQ-017 The sample counter SHALL clear to 0 at every capture edge, whether the window is accepted or discarded.
REQ-018 The minimum window count SHALL be 1, so no divide-by-zero path exists; a count of 0 SHALL still yield avg_out=0.
REQ-019 The FSM SHALL have three states: IDLE, DIVIDE and HOLD.
REQ-020 IDLE -> DIVIDE at C: latch sum_q=acc_sum (value present at C) and cnt_q=counter value.
REQ-021 DIVIDE SHALL run a restoring shift-subtract divider, one quotient bit per edge, exactly SUM_W (13) edges, C+1..C+13.
REQ-022 DIVIDE -> HOLD at C+14: out_valid=1; sum_out, cnt_out, avg_out and avg_sat load and stay stable until accepted.
REQ-023 A quotient greater than 2^AVG_W-1 SHALL produce avg_out=511 and avg_sat=1; otherwise avg_sat=0.
REQ-024 HOLD -> IDLE on an edge with out_valid=1 and out_ready=1; out_valid=0 after that edge, and data outputs hold their last values.
REQ-025 A capture edge in HOLD coincident with out_ready=1 SHALL accept the old result and start the new one (HOLD -> DIVIDE) with no loss.
REQ-026 A capture edge in DIVIDE, or in HOLD with out_ready=0, SHALL discard the new window, set overrun=1, and leave the current result untouched.
REQ-027 overrun SHALL remain set until reset.
REQ-028 Window counting SHALL continue in all states, independent of the FSM.
REQ-029 out_valid SHALL never deassert without acceptance, except on reset.

Reset
REQ-030 acc_rst2=1 SHALL asynchronously force the FSM to IDLE.
REQ-031 acc_rst2=1 SHALL asynchronously clear en_q, counter, sum_q, cnt_q, the divider registers, out_valid, sum_out, cnt_out, avg_out, avg_sat and overrun to 0.
REQ-032 Reset asserted mid-DIVIDE or in HOLD SHALL abandon the result with no out_valid pulse.
REQ-033 After deassertion, a window already open (acc_en=1) SHALL be counted from the first edge after release.

Verification
REQ-034 acc_en high 4 cycles, acc_sum=300 at C, out_ready=1 -> out_valid at C+14, sum_out=300, cnt_out=4, avg_out=75, avg_sat=0.
REQ-035 acc_en high 1 cycle, acc_sum=8191 -> avg_out=511, avg_sat=1, cnt_out=1.
REQ-036 acc_en high 40 cycles, acc_sum=3100 -> cnt_out=31, avg_out=100.
REQ-037 out_ready=0, second window closes in HOLD -> overrun=1, first result (sum 300, avg 75) unchanged; third window closes after acceptance -> processed normally.
REQ-038 Capture edge coincident with acceptance in HOLD -> old result accepted, new result valid 14 edges later, overrun=0.
REQ-039 acc_rst2 pulsed at C+6 -> all outputs 0, IDLE, no out_valid; next 2-cycle window with sum 50 -> avg_out=25.
